// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for the branch resolve unit.
// Holds the prediction entry, FSM state enum and PC increment.
package branch_resolve_unit_pkg;

    localparam logic [31:0] PC_INCR = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } pred_entry_t;

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_FLUSH  = 1'b1
    } brs_state_e;

endpackage

// File: rtl/branch_resolve_unit_pred_queue.sv
// In-order prediction FIFO with wrap-bit pointers and occupancy count.
// Clear has priority over push and pop.
module pred_queue
    import branch_resolve_unit_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = pred_entry_t
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   clr_i,
    input  logic   push_i,
    input  entry_t wdata_i,
    input  logic   pop_i,
    output entry_t rdata_o,
    output logic   empty_o,
    output logic   full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE      = (AW+1)'(1);

    entry_t      mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] count_q, count_d;
    logic        do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    // Accept/retire decisions and next pointer/occupancy values
    always_comb begin
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + ONE;
            if (do_push && !do_pop) count_d = count_q + ONE;
            if (do_pop && !do_push) count_d = count_q - ONE;
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful below the count
    always_ff @(posedge clk) begin
        if (do_push && !clr_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: compares resolutions with queued predictions.
// Optional BRANCH_RESOLVE_STATS_EN adds resolution/mispredict counters.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int PQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pred_push,
    input  logic [31:0] pred_pc,
    input  logic [31:0] pred_target,
    input  logic        pred_taken,
    input  logic        res_valid,
    input  logic [31:0] res_pc,
    input  logic [31:0] res_target,
    input  logic        res_taken,
    output logic        pq_full,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic        update_en,
    output logic [31:0] update_pc,
    output logic [31:0] update_target
`ifdef BRANCH_RESOLVE_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`endif
);

    brs_state_e  state_q, state_d;
    logic [31:0] redirect_q, redirect_d;
    logic        upd_en_q, upd_en_d;
    logic [31:0] upd_pc_q, upd_pc_d;
    logic [31:0] upd_tgt_q, upd_tgt_d;

    pred_entry_t wentry, head;
    logic        pq_empty;
    logic        active, res_go, hit;
    logic        p_taken, mispredict, need_upd;
    logic [31:0] p_target, fall_pc;

    assign active = (state_q == ST_NORMAL);
    assign res_go = res_valid && active;

    assign wentry.pc     = pred_pc;
    assign wentry.taken  = pred_taken;
    assign wentry.target = pred_target;

    pred_queue #(
        .DEPTH   (PQ_DEPTH),
        .entry_t (pred_entry_t)
    ) u_pq (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (mispredict),
        .push_i  (pred_push && active),
        .wdata_i (wentry),
        .pop_i   (res_go),
        .rdata_o (head),
        .empty_o (pq_empty),
        .full_o  (pq_full)
    );

    // A missing or mismatched head counts as a not-taken prediction
    always_comb begin
        fall_pc    = res_pc + PC_INCR;
        hit        = !pq_empty && (head.pc == res_pc);
        p_taken    = hit ? head.taken : 1'b0;
        p_target   = hit ? head.target : fall_pc;
        mispredict = res_go && ((p_taken != res_taken) ||
                     (p_taken && res_taken && (p_target != res_target)));
        need_upd   = res_go && res_taken &&
                     (!p_taken || (p_target != res_target));
    end

    // Next state plus redirect and BTB update capture
    always_comb begin
        state_d    = state_q;
        redirect_d = redirect_q;
        upd_en_d   = need_upd;
        upd_pc_d   = upd_pc_q;
        upd_tgt_d  = upd_tgt_q;
        unique case (state_q)
            ST_NORMAL: begin
                if (mispredict) begin
                    state_d    = ST_FLUSH;
                    redirect_d = res_taken ? res_target : fall_pc;
                end
            end
            ST_FLUSH: state_d = ST_NORMAL;
            default:  state_d = ST_NORMAL;
        endcase
        if (need_upd) begin
            upd_pc_d  = res_pc;
            upd_tgt_d = res_target;
        end
    end

    // FSM and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_NORMAL;
            redirect_q <= '0;
            upd_en_q   <= 1'b0;
            upd_pc_q   <= '0;
            upd_tgt_q  <= '0;
        end else begin
            state_q    <= state_d;
            redirect_q <= redirect_d;
            upd_en_q   <= upd_en_d;
            upd_pc_q   <= upd_pc_d;
            upd_tgt_q  <= upd_tgt_d;
        end
    end

    assign flush         = (state_q == ST_FLUSH);
    assign redirect_pc   = redirect_q;
    assign update_en     = upd_en_q;
    assign update_pc     = upd_pc_q;
    assign update_target = upd_tgt_q;

`ifdef BRANCH_RESOLVE_STATS_EN
    logic [31:0] br_cnt_q, mp_cnt_q;

    // Saturating resolution and mispredict counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else begin
            if (res_go && (br_cnt_q != '1))
                br_cnt_q <= br_cnt_q + 32'd1;
            if (mispredict && (mp_cnt_q != '1))
                mp_cnt_q <= mp_cnt_q + 32'd1;
        end
    end

    assign stat_branches    = br_cnt_q;
    assign stat_mispredicts = mp_cnt_q;
`endif

endmodule
